pipe_stage_buf: RTL
===================

# pipe_stage_buf

Parametrised inter-stage pipeline buffer for the 5-stage core, generalising the fixed ID/EX latch to any payload width and depth. It carries a packed payload plus a valid bit through DEPTH register stages. It supports stall, flush, and bubble insertion, and collapses bubbles so a stalled tail does not block upstream stages that still hold empty slots. One instance sits between each pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
Parameters:
- WIDTH, 32: payload width in bits; legal range 1 or more.
- DEPTH, 1: number of register stages; legal range 1 or more.
- ZERO_INVALID, 1: when 1, the payload of an invalid stage is forced to 0; when 0, the payload is held and don't-care.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- data_i  in  WIDTH  payload from the upstream stage.
- valid_i  in  1  payload on data_i is a real instruction.
- bubble_i  in  1  hazard unit request; treat the current input as invalid (insert a NOP).
- stall_i  in  1  downstream cannot accept; the last stage must hold.
- flush_i  in  1  branch/exception kill; invalidate every stage.
- accept_o  out  1  stage 0 loads this cycle (combinational).
- data_o  out  WIDTH  payload of the last stage.
- valid_o  out  1  valid bit of the last stage.
- count_o  out  $clog2(DEPTH+1)  number of valid stages.
- stall_cycles_o  out  32  perf counter; see Configuration.

## Operation
- State consists of v[k] and d[k] for k = 0..DEPTH-1. Stage 0 is the input side. The last stage drives data_o and valid_o.
- Advance enables are combinational:
  - en[DEPTH-1] = !stall_i || !v[DEPTH-1]
  - en[k] = en[k+1] || !v[k]
  - accept_o = en[0]
- When en[k] is high:
  - Stage 0 loads data_i, with valid bit valid_i && !bubble_i.
  - Stage k > 0 loads stage k-1.
- When en[k] is low, stage k holds.
- A stage that is vacated and not refilled becomes invalid. This arises naturally: stage k loads v[k-1], which may be 0.
- Priority, highest first: rst_i, flush_i, stall/collapse logic, bubble_i.
- Reset and flush both clear all v[k] to 0.
  - If ZERO_INVALID=1, they also clear all d[k] to 0.
  - Nothing is loaded from data_i in that cycle.
- Upstream handshake: if valid_i=1 and accept_o=0, upstream must hold data_i and valid_i unchanged. The buffer never drops an accepted item.
- bubble_i=1 loads an invalid entry whenever accept_o=1. With ZERO_INVALID=1, that entry's payload is 0.
- count_o equals popcount(v) and is registered; it updates with v.

## Timing
- Reset values: data_o = 0, valid_o = 0, count_o = 0, stall_cycles_o = 0. accept_o = 1 during reset whenever stall_i=0.
- Latency: DEPTH cycles from acceptance to appearance on data_o when there is no stall.
- Throughput: one item per cycle.
- stall_i, flush_i, bubble_i, and valid_i all act in the same cycle; there are no registered control inputs.
- Full and stalled: every v[k]=1 and stall_i=1 give accept_o=0, and the whole chain holds.
- Stalled with holes: stages upstream of the first invalid stage (counting from the output) still advance, and accept_o=1.
- Simultaneous flush_i and stall_i: the flush wins. The chain is cleared even though it was stalled.
- Reset during a stall or flush: the chain is cleared on the next edge, and stall_cycles_o also clears.
- DEPTH=1 reduces to a single register with hold, clear, and bubble.

## Configuration
- PIPE_STAGE_BUF_PERF_EN defined:
  - stall_cycles_o increments on each edge where valid_i && !accept_o && !flush_i.
  - The counter saturates at 32'hFFFF_FFFF.
  - It clears on rst_i only.
- PIPE_STAGE_BUF_PERF_EN undefined: the port remains present and is tied to 32'h0, and no counter logic is generated.

## Structure
- Shared package pipe_pkg holds:
  - the localparam for the NOP payload (32'h0000_0013, used by core-level wrappers)
  - the packed struct typedefs for each stage payload (id_ex_t, ex_mem_t, …), whose $bits set WIDTH
- One natural sub-module is pipe_stage_cell, a single stage register. Its ports are en, clr, v/d in, and v/d out.
  - pipe_stage_buf instantiates DEPTH cells in a generate loop.
  - The enable chain and the popcount live in the parent.

## Test plan
- Reset: hold rst_i high for 2 cycles with valid_i=1 and data_i=32'hDEAD_BEEF → valid_o=0, data_o=0, count_o=0 after release.
- Streaming with DEPTH=3: feed 32'h1, 2, 3, 4 on consecutive cycles → data_o shows 1, 2, 3, 4 starting on the third edge after the first accept, with valid_o continuously high.
- Collapse with DEPTH=3: fill v = {1,0,1}, assert stall_i → accept_o=1. After one edge v={1,1,1}; after the next, accept_o=0 and data_o is unchanged.
- Stall+flush collision: chain full, stall_i=1 and flush_i=1 in the same cycle → next cycle valid_o=0, count_o=0, accept_o=1.
- Bubble: bubble_i=1 with valid_i=1 and data_i=32'hABCD → the entry propagates invalid with payload 0 (ZERO_INVALID=1), and count_o is unchanged by it.
- Perf (macro defined): full chain, stall_i=1, valid_i=1 for 5 cycles → stall_cycles_o=5. With the macro undefined → stall_cycles_o stays 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: NOP payload and per-stage payload structs
// whose $bits set the WIDTH of each pipe_stage_buf instance.
package pipe_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        reg_wr;
  } mem_wb_t;

endpackage

// File: rtl/pipe_stage_cell.sv
// Single pipeline stage register: valid bit plus payload with load enable,
// synchronous reset and flush clear.
module pipe_stage_cell
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter bit          ZERO_INVALID = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             v_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             v_o,
  output logic [WIDTH-1:0] d_o
);

  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (clr_i) begin
      v_d = 1'b0;
      if (ZERO_INVALID) d_d = '0;
    end else if (en_i) begin
      v_d = v_i;
      d_d = (ZERO_INVALID && !v_i) ? '0 : d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign v_o = v_q;
  assign d_o = d_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// DEPTH-stage pipeline buffer with stall, flush, bubble and hole collapsing.
// Optional stall perf counter enabled by defining PIPE_STAGE_BUF_PERF_EN.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH        = 1,
  parameter bit          ZERO_INVALID = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       valid_i,
  input  logic                       bubble_i,
  input  logic                       stall_i,
  input  logic                       flush_i,
  output logic                       accept_o,
  output logic [WIDTH-1:0]           data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [31:0]                stall_cycles_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_s;
  logic [DEPTH-1:0] v_in;
  logic [DEPTH-1:0] en;
  logic [DEPTH-1:0] v_nxt;
  logic [WIDTH-1:0] d_s  [DEPTH];
  logic [WIDTH-1:0] d_in [DEPTH];
  logic [CW-1:0]    count_q, count_d;

  // Walk from the output back: a stage advances if the stage ahead advances
  // or it is itself empty, so any hole lets everything behind it move.
  always_comb begin
    logic acc;
    acc = !stall_i;
    en  = '0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      acc                = acc || !v_s[DEPTH-1-j];
      en[DEPTH-1-j]      = acc;
    end
  end

  assign accept_o = en[0];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign v_in[k] = valid_i && !bubble_i;
      assign d_in[k] = data_i;
    end else begin : g_body
      assign v_in[k] = v_s[k-1];
      assign d_in[k] = d_s[k-1];
    end

    pipe_stage_cell #(
      .WIDTH        (WIDTH),
      .ZERO_INVALID (ZERO_INVALID)
    ) u_cell (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (en[k]),
      .clr_i (flush_i),
      .v_i   (v_in[k]),
      .d_i   (d_in[k]),
      .v_o   (v_s[k]),
      .d_o   (d_s[k])
    );
  end

  // Count is registered from the next-state valid vector so it tracks v exactly.
  always_comb begin
    count_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      v_nxt[i] = flush_i ? 1'b0 : (en[i] ? v_in[i] : v_s[i]);
      count_d  = count_d + CW'(v_nxt[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;
  assign data_o  = d_s[DEPTH-1];
  assign valid_o = v_s[DEPTH-1];

`ifdef PIPE_STAGE_BUF_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (valid_i && !accept_o && !flush_i && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule
